// File: rtl/note_player.sv
// Queued note player: a small FIFO of 6-bit note codes feeding an IDLE/LOAD/PLAY/GAP
// sequencer that renders each note as a fixed-length square wave followed by silence.
module note_player #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned NOTE_CYCLES = 4096,
  parameter int unsigned GAP_CYCLES  = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [5:0]               note_in,
  input  logic                     en,
  input  logic                     flush,
  output logic                     tone_out,
  output logic                     playing,
  output logic [5:0]               cur_note,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = $clog2(NOTE_CYCLES);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  localparam logic [AW-1:0] PtrOne   = AW'(1);
  localparam logic [AW:0]   CntOne   = (AW + 1)'(1);
  localparam logic [AW:0]   CntFull  = (AW + 1)'(DEPTH);
  localparam logic [DW-1:0] DurLast  = DW'(NOTE_CYCLES - 1);
  localparam logic [GW-1:0] GapLast  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StPlay, StGap} state_e;

  state_e          state_q;
  logic [5:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            full_q, empty_q, overflow_q;
  logic [5:0]      cur_note_q;
  logic [10:0]     half_q, tone_cnt_q;
  logic [DW-1:0]   dur_cnt_q;
  logic [GW-1:0]   gap_cnt_q;
  logic            tone_q, playing_q;
  logic            pop, push_ok;

  always_comb begin
    pop     = (state_q == StIdle) && en && !empty_q;
    // A full queue can still take a push when the head leaves in the same cycle.
    push_ok = push && (!full_q || pop);
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) begin
      mem_q[wr_ptr_q] <= note_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      cur_note_q <= '0;
      half_q     <= '0;
      tone_cnt_q <= '0;
      dur_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tone_q     <= 1'b0;
      playing_q  <= 1'b0;
    end else if (flush) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      cur_note_q <= '0;
      tone_cnt_q <= '0;
      dur_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tone_q     <= 1'b0;
      playing_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      full_q     <= (count_d == CntFull);
      empty_q    <= (count_d == '0);
      overflow_q <= push && !push_ok;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrOne;

      case (state_q)
        StIdle: begin
          if (pop) begin
            cur_note_q <= mem_q[rd_ptr_q];
            state_q    <= StLoad;
          end
        end
        StLoad: begin
          half_q     <= 11'd64 + {1'b0, cur_note_q, 4'b0000};
          tone_cnt_q <= '0;
          dur_cnt_q  <= '0;
          tone_q     <= 1'b0;
          playing_q  <= 1'b1;
          state_q    <= StPlay;
        end
        StPlay: begin
          if (dur_cnt_q == DurLast) begin
            tone_q    <= 1'b0;
            playing_q <= 1'b0;
            gap_cnt_q <= '0;
            state_q   <= StGap;
          end else begin
            dur_cnt_q <= dur_cnt_q + DW'(1);
            if (tone_cnt_q == half_q - 11'd1) begin
              tone_cnt_q <= '0;
              // Note code 0 is a rest: the counter runs but the output never toggles.
              if (cur_note_q != 6'd0) tone_q <= ~tone_q;
            end else begin
              tone_cnt_q <= tone_cnt_q + 11'd1;
            end
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tone_out = tone_q;
  assign playing  = playing_q;
  assign cur_note = cur_note_q;
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player with short note/gap lengths and a 4-entry queue.
module tb_note_player;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NOTE  = 200;
  localparam int unsigned GAP   = 10;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic [5:0] note_in = '0;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic       tone_out, playing, full, empty, overflow;
  logic [5:0] cur_note;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  int ok, play_n, tone_err, play_err, first_rise, tone_hi;
  logic prev_tone, prev_p, exp_t;
  int got[$];
  int ovf_notes[5] = '{5, 9, 12, 3, 7};

  note_player #(
    .DEPTH      (DEPTH),
    .NOTE_CYCLES(NOTE),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .note_in (note_in),
    .en      (en),
    .flush   (flush),
    .tone_out(tone_out),
    .playing (playing),
    .cur_note(cur_note),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .overflow(overflow)
  );

  always #5 if (clk_run) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_play(input int limit, output int found);
    found = 0;
    for (int i = 0; i < limit; i++) begin
      if (playing === 1'b1) begin
        found = 1;
        break;
      end
      step();
    end
  endtask

  initial begin
    // Reset with the clock stopped
    #2 rst = 1'b1;
    #3;
    check("rst_tone", tone_out, 0);
    check("rst_playing", playing, 0);
    check("rst_cur_note", cur_note, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_overflow", overflow, 0);
    #2 rst = 1'b0;
    #1 clk_run = 1'b1;
    step();

    // Single note 1: half period 80
    en = 1'b1; push = 1'b1; note_in = 6'd1;
    step();
    push = 1'b0;
    check("single_count", count, 1);
    step();
    check("single_load", playing, 0);
    step();
    check("single_play", playing, 1);
    play_n = 0; tone_err = 0; play_err = 0; first_rise = -1; prev_tone = 1'b0;
    for (int j = 0; j < 210; j++) begin
      exp_t = (j < 200) ? 1'((j / 80) % 2) : 1'b0;
      if (playing === 1'b1) play_n++;
      if (tone_out !== exp_t) tone_err++;
      if ((playing === 1'b1) != (j < 200)) play_err++;
      if (tone_out === 1'b1 && !prev_tone && first_rise < 0) first_rise = j;
      prev_tone = tone_out;
      // Queue the next note during the last gap cycle to observe the return to IDLE
      if (j == 209) begin
        push = 1'b1; note_in = 6'd2;
      end
      step();
      push = 1'b0;
    end
    check("single_play_len", play_n, 200);
    check("single_first_rise", first_rise, 80);
    check("single_tone_wave", tone_err, 0);
    check("single_play_window", play_err, 0);
    step();
    check("gap_then_load", playing, 0);
    step();
    check("gap_then_play", playing, 1);
    for (int j = 0; j < 220; j++) step();
    check("note2_done", playing, 0);

    // Overflow and ordering
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; note_in = 6'(ovf_notes[i]);
      step();
      check("ovf_count", count, (i < 4) ? i + 1 : 4);
      check("ovf_pulse", overflow, (i == 4) ? 1 : 0);
    end
    push = 1'b0;
    check("ovf_full", full, 1);
    step();
    check("ovf_pulse_end", overflow, 0);
    check("ovf_count_hold", count, 4);
    en = 1'b1;
    prev_p = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (playing === 1'b1 && !prev_p) got.push_back(int'(cur_note));
      prev_p = playing;
      step();
    end
    check("order_len", got.size(), 4);
    check("order_0", (got.size() > 0) ? got[0] : 99, 5);
    check("order_1", (got.size() > 1) ? got[1] : 99, 9);
    check("order_2", (got.size() > 2) ? got[2] : 99, 12);
    check("order_3", (got.size() > 3) ? got[3] : 99, 3);
    check("order_empty", empty, 1);

    // Rest note
    push = 1'b1; note_in = 6'd0;
    step();
    push = 1'b0;
    wait_play(10, ok);
    check("rest_start", ok, 1);
    check("rest_cur_note", cur_note, 0);
    play_n = 0; tone_hi = 0;
    for (int j = 0; j < 210; j++) begin
      if (playing === 1'b1) play_n++;
      if (tone_out !== 1'b0) tone_hi++;
      step();
    end
    check("rest_play_len", play_n, 200);
    check("rest_silent", tone_hi, 0);

    // Flush mid-play with two queued
    push = 1'b1; note_in = 6'd1;
    step();
    push = 1'b0;
    wait_play(10, ok);
    check("flush_start", ok, 1);
    push = 1'b1; note_in = 6'd21;
    step();
    note_in = 6'd22;
    step();
    push = 1'b0;
    for (int j = 2; j < 100; j++) step();
    check("flush_pre_count", count, 2);
    check("flush_pre_tone", tone_out, 1);
    flush = 1'b1; push = 1'b1; note_in = 6'd33;
    step();
    flush = 1'b0; push = 1'b0;
    check("flush_playing", playing, 0);
    check("flush_tone", tone_out, 0);
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_cur_note", cur_note, 0);
    check("flush_overflow", overflow, 0);
    step();
    check("flush_idle", playing, 0);
    check("flush_push_ignored", count, 0);

    // en dropped mid-play
    push = 1'b1; note_in = 6'd2;
    step();
    note_in = 6'd4;
    step();
    push = 1'b0;
    wait_play(10, ok);
    check("en_start", ok, 1);
    check("en_cur_note", cur_note, 2);
    play_n = 0;
    for (int j = 0; j < 50; j++) begin
      if (playing === 1'b1) play_n++;
      step();
    end
    en = 1'b0;
    for (int j = 0; j < 300; j++) begin
      if (playing === 1'b1) play_n++;
      step();
    end
    check("en_note_completes", play_n, 200);
    check("en_parked_count", count, 1);
    check("en_parked_note", cur_note, 2);

    // Mid-play reset: note 4 has half period 128
    en = 1'b1;
    wait_play(10, ok);
    check("mrst_start", ok, 1);
    check("mrst_cur_note", cur_note, 4);
    push = 1'b1; note_in = 6'd7;
    step();
    push = 1'b0;
    for (int j = 1; j < 130; j++) step();
    check("mrst_pre_tone", tone_out, 1);
    check("mrst_pre_count", count, 1);
    #2 rst = 1'b1;
    #1;
    check("mrst_tone", tone_out, 0);
    check("mrst_playing", playing, 0);
    check("mrst_count", count, 0);
    check("mrst_cur_note", cur_note, 0);
    #1 rst = 1'b0;
    step();
    check("mrst_after_playing", playing, 0);
    check("mrst_after_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
